// File: rtl/pipelined_prefix_adder_if.sv
// Operand/result bundle for the pipelined prefix adder: request side (a, b, cin, sub, in_tag) and result side.
// Latency: none; this is wiring only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: master drives operands and out_ready; slave (the adder) drives in_ready and the result fields.
interface pipelined_prefix_adder_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, a, b, cin, sub, in_tag, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero, out_tag
    );

    modport slave (
        input  in_valid, a, b, cin, sub, in_tag, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero, out_tag
    );
endinterface

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with carry-out, signed-overflow, zero flags and a pass-through tag.
// Latency: NSTG+1 register stages (input register plus one per group of LEVELS_PER_STAGE prefix levels).
// Backpressure: out_valid & ~out_ready freezes every stage, bubbles included, and drops in_ready.
// Ports: clk, reset (synchronous, active high), bus (slave modport carrying both handshakes and data).
module pipelined_prefix_adder #(
    parameter int WIDTH            = 32,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int TAG_W            = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    pipelined_prefix_adder_if.slave  bus
);
    localparam int L    = $clog2(WIDTH);
    localparam int NSTG = (LEVELS_PER_STAGE < 1) ? 1 :
                          (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $fatal(1, "pipelined_prefix_adder: WIDTH must be a power of two >= 4");
    end
    if (LEVELS_PER_STAGE < 1 || LEVELS_PER_STAGE > L) begin : g_bad_levels
        $fatal(1, "pipelined_prefix_adder: LEVELS_PER_STAGE must be in 1..log2(WIDTH)");
    end

    // Index 0 of every G/P vector is the virtual bit -1 holding the carry-in
    // (g=c0, p=0); index i+1 is operand bit i.
    logic [NSTG:0]    vld_q;
    logic [WIDTH:0]   g_q  [0:NSTG];
    logic [WIDTH:0]   p_q  [0:NSTG];
    logic [WIDTH-1:0] pb_q [0:NSTG];
    logic [TAG_W-1:0] tag_q[0:NSTG];

    logic [WIDTH:0]   g_d  [1:NSTG];
    logic [WIDTH:0]   p_d  [1:NSTG];

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign stall = vld_q[NSTG] & ~bus.out_ready;
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c0    = bus.sub ? 1'b1 : bus.cin;

    // One Kogge-Stone level: every position at or above the span combines
    // with the group that ends just below it.
    function automatic logic [2*(WIDTH+1)-1:0] ks_level(
        input logic [WIDTH:0] gi,
        input logic [WIDTH:0] pi,
        input int             k
    );
        logic [WIDTH:0] go;
        logic [WIDTH:0] po;
        int             d;
        go = gi;
        po = pi;
        d  = 1 << k;
        for (int i = d; i <= WIDTH; i++) begin
            go[i] = gi[i] | (pi[i] & gi[i-d]);
            po[i] = pi[i] & pi[i-d];
        end
        return {go, po};
    endfunction

    // Stage st evaluates levels (st-1)*LEVELS_PER_STAGE upward; the last
    // stage simply runs out of levels when L is not a multiple.
    always_comb begin
        logic [WIDTH:0] gt;
        logic [WIDTH:0] pt;
        gt = '0;
        pt = '0;
        for (int st = 1; st <= NSTG; st++) begin
            gt = g_q[st-1];
            pt = p_q[st-1];
            for (int k = 0; k < L; k++) begin
                if (k / LEVELS_PER_STAGE == st - 1) begin
                    {gt, pt} = ks_level(gt, pt, k);
                end
            end
            g_d[st] = gt;
            p_d[st] = pt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int st = 0; st <= NSTG; st++) begin
                g_q[st]   <= '0;
                p_q[st]   <= '0;
                pb_q[st]  <= '0;
                tag_q[st] <= '0;
            end
        end else if (!stall) begin
            vld_q[0] <= bus.in_valid;
            g_q[0]   <= {bus.a & b_eff, c0};
            p_q[0]   <= {bus.a ^ b_eff, 1'b0};
            pb_q[0]  <= bus.a ^ b_eff;
            tag_q[0] <= bus.in_tag;
            for (int st = 1; st <= NSTG; st++) begin
                vld_q[st] <= vld_q[st-1];
                g_q[st]   <= g_d[st];
                p_q[st]   <= p_d[st];
                pb_q[st]  <= pb_q[st-1];
                tag_q[st] <= tag_q[st-1];
            end
        end
    end

    // After L levels index i (< 2^L = WIDTH) holds the full prefix down to
    // bit -1, i.e. the carry into bit i. The MSB position spans only WIDTH
    // positions, so the carry-out needs one last merge with bit -1.
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum;
    logic             cout_w;
    logic             unused_p;

    assign carry    = g_q[NSTG][WIDTH-1:0];
    assign sum      = pb_q[NSTG] ^ carry;
    assign cout_w   = g_q[NSTG][WIDTH] | (p_q[NSTG][WIDTH] & g_q[NSTG][0]);
    assign unused_p = ^p_q[NSTG][WIDTH-1:0];

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = vld_q[NSTG];
    assign bus.s         = sum;
    assign bus.cout      = cout_w;
    assign bus.ovf       = carry[WIDTH-1] ^ cout_w;
    assign bus.zero      = ~|sum;
    assign bus.out_tag   = tag_q[NSTG];
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: three configurations (32/2, 8/1, 64/3) against an arithmetic reference.
// Latency: checks result appearance LAT cycles after acceptance when the output is never stalled.
// Backpressure: drives stalls on out_ready and checks in_ready, output hold, ordering and reset flushing.
module tb_pipelined_prefix_adder;
    typedef struct {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   cur    = 0;
    bit   chk_lat = 1'b0;
    int   lat_tab [3] = '{4, 4, 3};
    int   w_tab   [3] = '{32, 8, 64};
    exp_t q[$];

    logic        d_vld [3];
    logic [63:0] d_a   [3];
    logic [63:0] d_b   [3];
    logic        d_cin [3];
    logic        d_sub [3];
    logic [3:0]  d_tag [3];
    logic        d_ordy[3];

    logic        o_irdy[3];
    logic        o_vld [3];
    logic [63:0] o_s   [3];
    logic        o_cout[3];
    logic        o_ovf [3];
    logic        o_zero[3];
    logic [3:0]  o_tag [3];

    pipelined_prefix_adder_if #(.WIDTH(32), .TAG_W(4)) if0 ();
    pipelined_prefix_adder_if #(.WIDTH(8),  .TAG_W(4)) if1 ();
    pipelined_prefix_adder_if #(.WIDTH(64), .TAG_W(4)) if2 ();

    pipelined_prefix_adder #(.WIDTH(32), .LEVELS_PER_STAGE(2), .TAG_W(4)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    pipelined_prefix_adder #(.WIDTH(8),  .LEVELS_PER_STAGE(1), .TAG_W(4)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    pipelined_prefix_adder #(.WIDTH(64), .LEVELS_PER_STAGE(3), .TAG_W(4)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    assign if0.in_valid = d_vld[0];  assign if0.a = d_a[0][31:0]; assign if0.b = d_b[0][31:0];
    assign if0.cin = d_cin[0];       assign if0.sub = d_sub[0];   assign if0.in_tag = d_tag[0];
    assign if0.out_ready = d_ordy[0];
    assign o_irdy[0] = if0.in_ready; assign o_vld[0] = if0.out_valid; assign o_s[0] = {32'd0, if0.s};
    assign o_cout[0] = if0.cout;     assign o_ovf[0] = if0.ovf;       assign o_zero[0] = if0.zero;
    assign o_tag[0] = if0.out_tag;

    assign if1.in_valid = d_vld[1];  assign if1.a = d_a[1][7:0];  assign if1.b = d_b[1][7:0];
    assign if1.cin = d_cin[1];       assign if1.sub = d_sub[1];   assign if1.in_tag = d_tag[1];
    assign if1.out_ready = d_ordy[1];
    assign o_irdy[1] = if1.in_ready; assign o_vld[1] = if1.out_valid; assign o_s[1] = {56'd0, if1.s};
    assign o_cout[1] = if1.cout;     assign o_ovf[1] = if1.ovf;       assign o_zero[1] = if1.zero;
    assign o_tag[1] = if1.out_tag;

    assign if2.in_valid = d_vld[2];  assign if2.a = d_a[2];       assign if2.b = d_b[2];
    assign if2.cin = d_cin[2];       assign if2.sub = d_sub[2];   assign if2.in_tag = d_tag[2];
    assign if2.out_ready = d_ordy[2];
    assign o_irdy[2] = if2.in_ready; assign o_vld[2] = if2.out_valid; assign o_s[2] = if2.s;
    assign o_cout[2] = if2.cout;     assign o_ovf[2] = if2.ovf;       assign o_zero[2] = if2.zero;
    assign o_tag[2] = if2.out_tag;

    // Reference: plain modular arithmetic; overflow from operand/result signs.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub,
                                   input logic [3:0] tag, input int w);
        exp_t        r;
        logic [64:0] m;
        logic [64:0] am;
        logic [64:0] bm;
        logic [64:0] full;
        logic        sa;
        logic        sb;
        logic        sr;
        m  = (65'd1 << w) - 65'd1;
        am = {1'b0, a} & m;
        bm = {1'b0, b} & m;
        if (!sub) begin
            full   = am + bm + 65'(cin);
            r.cout = full[w];
        end else begin
            full   = (am - bm) & m;
            r.cout = (am >= bm);
        end
        r.s    = full[63:0] & m[63:0];
        sa     = am[w-1];
        sb     = bm[w-1];
        sr     = r.s[w-1];
        r.ovf  = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        r.zero = (r.s == 64'd0);
        r.tag  = tag;
        r.cyc  = 0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: observe both handshakes at the falling edge, then advance.
    task automatic step();
        exp_t e;
        int   id;
        id = cur;
        @(negedge clk);
        if (!reset) begin
            if (o_vld[id] && !d_ordy[id]) begin
                chk("stall_in_ready", 64'(o_irdy[id]), 64'd0);
                if (q.size() > 0) begin
                    chk("stall_hold_s", o_s[id], q[0].s);
                    chk("stall_hold_tag", 64'(o_tag[id]), 64'(q[0].tag));
                end
            end
            if (o_vld[id] && d_ordy[id]) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 64'(o_vld[id]), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("s", o_s[id], e.s);
                    chk("cout", 64'(o_cout[id]), 64'(e.cout));
                    chk("ovf", 64'(o_ovf[id]), 64'(e.ovf));
                    chk("zero", 64'(o_zero[id]), 64'(e.zero));
                    chk("tag", 64'(o_tag[id]), 64'(e.tag));
                    if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'(lat_tab[id]));
                end
            end
            if (d_vld[id] && o_irdy[id]) begin
                e = model(d_a[id], d_b[id], d_cin[id], d_sub[id], d_tag[id], w_tab[id]);
                e.cyc = cyc;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub, input logic [3:0] tag, input logic ordy);
        d_vld[cur] = v;   d_a[cur] = a;     d_b[cur] = b;
        d_cin[cur] = cin; d_sub[cur] = sub; d_tag[cur] = tag;
        d_ordy[cur] = ordy;
        step();
    endtask

    task automatic drain(input int max);
        d_vld[cur]  = 1'b0;
        d_ordy[cur] = 1'b1;
        for (int i = 0; i < max && q.size() > 0; i++) step();
        chk("drain_empty", 64'(q.size()), 64'd0);
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic chk_reset(input int id);
        chk("rst_out_valid", 64'(o_vld[id]), 64'd0);
        chk("rst_in_ready", 64'(o_irdy[id]), 64'd1);
        chk("rst_s", o_s[id], 64'd0);
        chk("rst_cout", 64'(o_cout[id]), 64'd0);
        chk("rst_ovf", 64'(o_ovf[id]), 64'd0);
        chk("rst_zero", 64'(o_zero[id]), 64'd1);
        chk("rst_tag", 64'(o_tag[id]), 64'd0);
    endtask

    task automatic rand_op(input logic v, input logic [3:0] tag, input logic ordy);
        drive(v, {$urandom(), $urandom()}, {$urandom(), $urandom()},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tag, ordy);
    endtask

    // Three operations in flight, then reset with in_valid still high:
    // nothing may come out afterwards.
    task automatic reset_inflight(input int id);
        cur = id;
        for (int i = 0; i < 3; i++) rand_op(1'b1, 4'(i + 9), 1'b1);
        d_vld[cur] = 1'b1;
        reset = 1'b1;
        step();
        chk_reset(id);
        reset = 1'b0;
        q.delete();
        d_vld[cur] = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rand_op(1'b1, 4'd2, 1'b1);
        drain(20);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            d_vld[i] = 1'b0; d_a[i] = '0;   d_b[i] = '0;
            d_cin[i] = 1'b0; d_sub[i] = 1'b0; d_tag[i] = '0;
            d_ordy[i] = 1'b1;
        end
        reset = 1'b1;
        step();
        step();
        chk_reset(0);
        chk_reset(1);
        chk_reset(2);
        reset = 1'b0;

        // Directed cases on the default configuration.
        cur = 0;
        chk_lat = 1'b1;
        drive(1'b1, 64'h1, 64'hFFFF_FFFF, 1'b0, 1'b0, 4'd3, 1'b1);
        drain(20);
        drive(1'b1, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 4'd5, 1'b1);
        drive(1'b1, 64'h8000_0000, 64'h1, 1'b0, 1'b1, 4'd6, 1'b1);
        drain(20);
        drive(1'b1, 64'h5, 64'h7, 1'b1, 1'b1, 4'd7, 1'b1);
        drain(20);

        // Back-to-back stream, one result per cycle.
        for (int i = 0; i < 16; i++) rand_op(1'b1, 4'(i), 1'b1);
        drain(20);

        // Five-cycle stall mid-stream with in_valid held high.
        chk_lat = 1'b0;
        for (int i = 0; i < 20; i++) rand_op(1'b1, 4'(i), (i >= 8 && i < 13) ? 1'b0 : 1'b1);
        drain(40);

        // Random valid/ready mix, including stalls with bubbles in the pipe.
        for (int i = 0; i < 60; i++) rand_op(1'($urandom_range(0, 1)), 4'(i), 1'($urandom_range(0, 3) != 0));
        drain(40);

        reset_inflight(0);

        // 8-bit, one level per stage: every operand pair.
        cur = 1;
        chk_lat = 1'b1;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                drive(1'b1, 64'(a), 64'(b), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      4'(a + b), 1'b1);
            end
        end
        drain(20);

        // 64-bit, three levels per stage.
        cur = 2;
        drive(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4'd1, 1'b1);
        drive(1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 4'd2, 1'b1);
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4'd3, 1'b1);
        drive(1'b1, 64'h0, 64'h0, 1'b0, 1'b1, 4'd4, 1'b1);
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 4'd5, 1'b1);
        for (int i = 0; i < 100; i++) rand_op(1'b1, 4'(i), 1'b1);
        drain(20);
        chk_lat = 1'b0;
        for (int i = 0; i < 150; i++) rand_op(1'($urandom_range(0, 1)), 4'(i), 1'($urandom_range(0, 2) != 0));
        drain(40);

        reset_inflight(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_prefix_adder.md
Name: pipelined_prefix_adder

Overview:
Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor. It generalises the team's fixed 32-bit combinational prefix adder in three ways: arbitrary power-of-two width, a configurable number of prefix levels per pipeline stage, and an add/subtract mode. Operands enter through a valid/ready handshake and leave through another with full backpressure. It also produces carry-out, signed-overflow and zero flags, plus a pass-through tag. It sits in the datapath between operand-issue logic and writeback.

Parameters:
WIDTH, 32, operand/sum width; power of two, at least 4.
LEVELS_PER_STAGE, 2, prefix levels evaluated combinationally between pipeline registers; 1..log2(WIDTH).
TAG_W, 4, width of the user tag carried alongside each operation.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  operation present on a/b/cin/sub/in_tag.
in_ready  out  1  block can accept an operation this cycle.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
cin  in  1  carry-in; ignored when sub=1.
sub  in  1  0: a+b+cin; 1: a+~b+1 (a-b).
in_tag  in  TAG_W  user tag.
out_valid  out  1  result present.
out_ready  in  1  consumer accepts result this cycle.
s  out  WIDTH  sum/difference.
cout  out  1  carry out of the MSB; for sub, 1 means no borrow.
ovf  out  1  two's-complement overflow.
zero  out  1  s == 0.
out_tag  out  TAG_W  tag of the result.

Behaviour:
- Definitions:
  - L = log2(WIDTH) prefix levels.
  - NSTG = ceil(L / LEVELS_PER_STAGE).
  - Pipeline depth LAT = NSTG + 1 register stages.
  - Defaults give L=5, NSTG=3, LAT=4.
- Stage 0 (input register):
  - Captures a, b_eff, c0 and tag.
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
  - Bit-level g = a & b_eff, p = a ^ b_eff; c0 is injected as the generate of a virtual bit -1 with p=0.
- Stages 1..NSTG:
  - Each evaluates the next LEVELS_PER_STAGE Kogge-Stone levels, using span 2^k at level k.
  - Each registers the group G/P for all bit positions plus the original p.
  - The final stage may hold fewer than LEVELS_PER_STAGE levels.
- Output:
  - s[i] = p[i] ^ G[i-1:-1].
  - cout = G[WIDTH-1:-1].
  - ovf = carry into MSB XOR cout.
  - zero = (s == 0).
  - These are combinational from the last stage register; out_tag comes from the last stage.
- Each stage carries a valid bit. out_valid is the valid bit of the last stage.
- Latency:
  - An operation accepted on edge n (in_valid & in_ready) is presented with out_valid=1 after edge n+LAT-1.
  - With defaults, accepted at edge 0, visible after edge 3.
  - Throughput is one operation per cycle with no stall.
- Stall:
  - stall = out_valid & ~out_ready.
  - While stall=1, every stage register holds its value and in_ready=0.
  - in_ready = ~stall, and does not depend on in_valid.
  - Bubbles do not collapse; a stall freezes the whole pipe, including empty stages.
- Output hold:
  - While out_valid=1 and out_ready=0, s/cout/ovf/zero/out_tag are stable.
- Simultaneous events:
  - When out_ready=1 and in_valid=1 in the same cycle with the pipe full, the result is consumed and the new operation is accepted on the same edge.
- Reset:
  - On any edge with reset=1, all valid bits clear.
  - out_valid=0 and in_ready=1 from the following cycle.
  - Data registers clear to 0, so s=0, cout=0, ovf=0, zero=1 and out_tag=0 after reset.
  - Reset applied mid-operation discards all in-flight operations; none are emitted afterwards.
  - in_valid is ignored while reset=1.
- Arithmetic:
  - Modulo 2^WIDTH.
  - No internal width growth beyond the virtual carry position -1.
- Elaboration:
  - An illegal WIDTH or LEVELS_PER_STAGE must cause a fatal elaboration error.

Test Plan:
1. Add, defaults: a=0x0000_0001, b=0xFFFF_FFFF, cin=0, sub=0, tag=3 -> after 4 edges: s=0, cout=1, ovf=0, zero=1, out_tag=3.
2. Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> s=0x8000_0000, cout=0, ovf=1; then sub with a=0x8000_0000, b=1 -> s=0x7FFF_FFFF, cout=1, ovf=1.
3. Subtract with borrow: a=5, b=7, sub=1, cin=1 (ignored) -> s=0xFFFF_FFFE, cout=0, ovf=0, zero=0.
4. Back-to-back stream: 16 random operations with out_ready held at 1 -> one result per cycle, in order, with tags matching, checked against a+b+cin / a-b.
5. Backpressure: drop out_ready to 0 for 5 cycles mid-stream with in_valid=1 -> in_ready=0 during the stall, outputs frozen, no loss or duplication, order preserved once released.
6. Parameter sweep and reset: WIDTH=8/LEVELS_PER_STAGE=1 (LAT=4) and WIDTH=64/LEVELS_PER_STAGE=3 (LAT=3), exhaustive on 8-bit -> all correct; assert reset with 3 operations in flight -> out_valid=0 next cycle and the 3 operations are never emitted.
